// File: rtl/im2col_feeder.sv
// im2col_feeder: loads a feature map into local RAM, then streams zero-padded im2col windows
// with a 1-cycle RAM read and a two-entry skid buffer on the output.
module im2col_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            stride_i,
  input  logic [1:0]            pad_i,
  input  logic [ADDR_WIDTH-1:0] k_dim_i,
  input  logic [ADDR_WIDTH-1:0] in_rows_i,
  input  logic [ADDR_WIDTH-1:0] in_cols_i,
  input  logic [ADDR_WIDTH-1:0] chans_i,
  input  logic [ADDR_WIDTH-1:0] o_dim_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  cfg_err_o,
  output logic [1:0]            state_o
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * AW;
  localparam int RW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_e;
  state_e state_q, state_d;
  logic [1:0] stride_q, pad_q;
  logic [AW-1:0] k_q, rows_q, cols_q, chans_q, o_q;
  logic [AW-1:0] c_q, kx_q, ky_q, ox_q, oy_q;
  logic [PW-1:0] wr_addr_q, total_q;
  logic gen_done_q, s1_v_q, s1_pad_q, s1_last_q, l0_q, l1_q, cfg_err_q;
  logic [DW-1:0] rdata_q, e0_q, e1_q;
  logic [1:0] cnt_q;
  logic [DW-1:0] mem [DEPTH];
  logic [3*AW-1:0] need;
  logic [PW+1:0] r, q;
  logic [RW-1:0] raddr;
  logic [2:0] occ;
  logic [DW-1:0] pd;
  logic cfg_ok, start_ok, wr_en, wr_last, pop, push, issue, inb;
  logic c_w, kx_w, ky_w, ox_w, oy_w, last_c;
  always_comb begin
    need     = (3*AW)'(in_rows_i) * (3*AW)'(in_cols_i) * (3*AW)'(chans_i);
    cfg_ok   = need <= (3*AW)'(DEPTH) && k_dim_i != '0 && o_dim_i != '0 && stride_i != 2'd0;
    start_ok = state_q == IDLE && start_i;
    wr_en    = state_q == LOAD && in_valid_i;
    wr_last  = wr_addr_q == total_q - PW'(1);
    c_w      = c_q == chans_q - AW'(1);
    kx_w     = kx_q == k_q - AW'(1);
    ky_w     = ky_q == k_q - AW'(1);
    ox_w     = ox_q == o_q - AW'(1);
    oy_w     = oy_q == o_q - AW'(1);
    last_c   = c_w && kx_w && ky_w && ox_w && oy_w;
    // Padded coordinates go negative; the MSB of these wide sums acts as the sign.
    r        = (PW+2)'(oy_q) * (PW+2)'(stride_q) + (PW+2)'(ky_q) - (PW+2)'(pad_q);
    q        = (PW+2)'(ox_q) * (PW+2)'(stride_q) + (PW+2)'(kx_q) - (PW+2)'(pad_q);
    inb      = !r[PW+1] && !q[PW+1] && r[PW:0] < (PW+1)'(rows_q) && q[PW:0] < (PW+1)'(cols_q);
    raddr    = RW'((r[PW-1:0] * PW'(cols_q) + q[PW-1:0]) * PW'(chans_q) + PW'(c_q));
    pop      = cnt_q != 2'd0 && out_ready_i;
    push     = s1_v_q;
    pd       = s1_pad_q ? '0 : rdata_q;
    // Issue only if the skid buffer can still absorb the word even if the consumer stalls.
    occ      = 3'(cnt_q) + 3'(s1_v_q) - 3'(pop);
    issue    = state_q == STREAM && !gen_done_q && occ <= 3'd1;
    state_d  = (start_ok && cfg_ok) ? LOAD :
               (wr_en && wr_last) ? STREAM :
               (state_q == STREAM && pop && l0_q) ? DRAIN :
               (state_q == DRAIN) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q[RW-1:0]] <= in_data_i;
    if (issue && inb) rdata_q <= mem[raddr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {stride_q, pad_q, k_q, rows_q, cols_q, chans_q, o_q} <= '0;
      {c_q, kx_q, ky_q, ox_q, oy_q, wr_addr_q, total_q} <= '0;
      {gen_done_q, s1_v_q, s1_pad_q, s1_last_q, l0_q, l1_q, cfg_err_q} <= '0;
      {e0_q, e1_q, cnt_q} <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= start_ok && !cfg_ok;
      if (start_ok) begin
        {stride_q, pad_q, k_q, rows_q, cols_q, chans_q, o_q} <=
          {stride_i, pad_i, k_dim_i, in_rows_i, in_cols_i, chans_i, o_dim_i};
        total_q <= need[PW-1:0];
        {c_q, kx_q, ky_q, ox_q, oy_q, wr_addr_q, gen_done_q} <= '0;
      end
      if (wr_en) wr_addr_q <= wr_addr_q + PW'(1);
      if (issue) begin
        c_q <= c_w ? '0 : c_q + AW'(1);
        if (c_w) kx_q <= kx_w ? '0 : kx_q + AW'(1);
        if (c_w && kx_w) ky_q <= ky_w ? '0 : ky_q + AW'(1);
        if (c_w && kx_w && ky_w) ox_q <= ox_w ? '0 : ox_q + AW'(1);
        if (c_w && kx_w && ky_w && ox_w) oy_q <= oy_w ? '0 : oy_q + AW'(1);
        gen_done_q <= last_c;
      end
      s1_v_q    <= issue;
      s1_pad_q  <= !inb;
      s1_last_q <= last_c;
      e0_q  <= pop ? ((push && cnt_q == 2'd1) ? pd : e1_q) : (push && cnt_q == 2'd0) ? pd : e0_q;
      l0_q  <= pop ? ((push && cnt_q == 2'd1) ? s1_last_q : l1_q) : (push && cnt_q == 2'd0) ? s1_last_q : l0_q;
      e1_q  <= (push && (pop ? cnt_q == 2'd2 : cnt_q == 2'd1)) ? pd : e1_q;
      l1_q  <= (push && (pop ? cnt_q == 2'd2 : cnt_q == 2'd1)) ? s1_last_q : l1_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
  assign in_ready_o  = state_q == LOAD;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o  = e0_q;
  assign out_last_o  = l0_q && cnt_q != 2'd0;
  assign busy_o      = state_q != IDLE;
  assign cfg_err_o   = cfg_err_q;
  assign state_o     = state_q;
endmodule
